sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Parametrised N-to-1 arbiter for the SRAM-like bus (req / addr_ok / data_ok split-transaction protocol) that sits between the CPU core's master ports (instruction fetch, data access, and later additional masters) and the single downstream memory port. It selects one requesting master per address handshake, holds that choice until the handshake completes, and records the granted master ID in an in-order FIFO. Each returning `data_ok` is then routed to the master that owns it. Up to OUTSTANDING transactions may be in flight.

## Interface
Parameters:
- NUM_MASTERS, 2: number of upstream masters; index 0 is highest fixed priority.
- OUTSTANDING, 4: maximum accepted-but-unanswered transactions (ID FIFO depth, ≥1).
- IDW, $clog2(NUM_MASTERS) (min 1): internal master-ID width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  NUM_MASTERS  per-master request.
- m_wr  in  NUM_MASTERS  per-master write flag.
- m_size  in  2*NUM_MASTERS  per-master size (0 byte, 1 half, 2 word).
- m_addr  in  32*NUM_MASTERS  per-master address.
- m_wdata  in  32*NUM_MASTERS  per-master write data.
- m_addr_ok  out  NUM_MASTERS  address handshake, one-hot or zero.
- m_data_ok  out  NUM_MASTERS  data return strobe, one-hot or zero.
- m_rdata  out  32  read data, broadcast; equals s_rdata.
- s_req, s_wr, s_size[1:0], s_addr[31:0], s_wdata[31:0]  out  downstream request, muxed from the granted master.
- s_addr_ok  in  1  downstream address accept.
- s_data_ok  in  1  downstream data return, in order.
- s_rdata  in  32  downstream read data.
- err_unexp  out  1  sticky flag: `s_data_ok` arrived while the ID FIFO was empty.

## Operation
- Grant selection (unlocked): choose among asserted m_req by the policy below. Grant is combinational from m_req.
- Lock: if s_req=1 and s_addr_ok=0 at a clock edge, register lock=1 and lock_id=grant. While locked, the grant is forced to lock_id regardless of other requests. Lock clears on the cycle in which s_req & s_addr_ok.
- s_req = (|m_req) & (count < OUTSTANDING) & ~reset. s_wr/size/addr/wdata come from the granted master; their value is don't-care when s_req=0.
- m_addr_ok[g] = s_req & s_addr_ok & (g == grant); all other bits are 0.
- Push: s_req & s_addr_ok writes grant into the ID FIFO and increments count.
- Pop: s_data_ok & (count≠0) pulses m_data_ok[head_id] in the same cycle and pops the FIFO.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full (count==OUTSTANDING): s_req is forced to 0 even if a pop occurs in the same cycle. Requests are re-exposed the following cycle.
- Empty: s_data_ok is ignored (no m_data_ok pulse) and err_unexp is set to 1, where it stays until reset.
- FIFO pointers wrap modulo OUTSTANDING. count has range 0..OUTSTANDING.
- Reset (any time, including mid-transaction): count=0, pointers=0, lock=0, err_unexp=0, RR pointer=0. In-flight IDs are discarded. While reset is high, all outputs are 0 except m_rdata, which passes s_rdata.

## Timing
- Zero-cycle combinational path from m_req to s_req, and from s_addr_ok/s_data_ok to m_addr_ok/m_data_ok.
- Transaction occupancy begins at the edge where the address handshake occurs. A data_ok for it may arrive at the earliest on the next cycle.
- Grant changes only at handshake edges or while unlocked. A master that has been exposed on s_req never has its request withdrawn by the arbiter, except when the full condition applies before the first exposure.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. Search starts at rr_ptr. After each push, rr_ptr becomes (grant+1) mod NUM_MASTERS.
- ARB_RR_EN undefined: fixed priority, with the lowest index winning. rr_ptr is not implemented.

## Test plan
- Fixed priority, m_req=2'b11, s_addr_ok=1 continuously, data_ok returned after 1 cycle -> four back-to-back grants all to master 0, and m_data_ok=2'b01 for each.
- ARB_RR_EN, m_req=2'b11 held for 4 handshakes -> grant order 0,1,0,1; m_data_ok pulses in order 01,10,01,10 with s_rdata values 0x11,0x22,0x33,0x44 passed through unchanged.
- Lock: master 1 requests alone with s_addr_ok=0 for 3 cycles, then master 0 raises req -> s_addr tracks master 1 until its addr_ok, and only afterwards switches to master 0.
- OUTSTANDING=4, 4 handshakes with no data_ok -> s_req=0 on the 5th cycle even with s_data_ok=1 that cycle. s_req returns to 1 the next cycle, and count stays ≤4.
- s_data_ok=1 with FIFO empty -> no m_data_ok bit set, err_unexp=1 and stays 1 until reset.
- Reset asserted with 2 transactions in flight -> all outputs 0 immediately. After release, s_data_ok sets err_unexp and new requests are granted normally.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: N-to-1 arbiter for the split-transaction SRAM-like bus.
// One master is granted per address handshake and held (locked) until the
// handshake completes; granted IDs go into an in-order FIFO so each returning
// data_ok can be steered back to its owner.
// Optional feature macro: ARB_RR_EN (round-robin instead of fixed priority).
module sram_like_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int OUTSTANDING = 4,
  parameter int IDW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_wr,
  input  logic [2*NUM_MASTERS-1:0]  m_size,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_addr_ok,
  output logic [NUM_MASTERS-1:0]    m_data_ok,
  output logic [31:0]               m_rdata,
  output logic                      s_req,
  output logic                      s_wr,
  output logic [1:0]                s_size,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic                      s_addr_ok,
  input  logic                      s_data_ok,
  input  logic [31:0]               s_rdata,
  output logic                      err_unexp
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic           err_q, err_d;
  logic [IDW-1:0] id_fifo_q [OUTSTANDING];

  logic [IDW-1:0] pick;
  logic           found;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] head_id;
  logic           has_room, push, pop;
  logic           wr_mux;
  logic [1:0]     size_mux;
  logic [31:0]    addr_mux, wdata_mux;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef ARB_RR_EN
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin pick: first requester at or above rr_ptr, else wrap from 0
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && m_req[j] && (IDW'(j) >= rr_ptr_q)) begin
        pick  = IDW'(j);
        found = 1'b1;
      end
    end
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && m_req[j]) begin
        pick  = IDW'(j);
        found = 1'b1;
      end
    end
  end

  // Pointer moves just past the master that completed its handshake
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (grant == IDW'(NUM_MASTERS - 1)) ? '0 : grant + IDW'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority pick: lowest requesting index wins
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && m_req[j]) begin
        pick  = IDW'(j);
        found = 1'b1;
      end
    end
  end
`endif

  // A master already exposed on s_req keeps the grant until accepted
  assign grant    = lock_q ? lock_id_q : pick;
  assign has_room = (count_q < CW'(OUTSTANDING));
  assign s_req    = (|m_req) & has_room & ~reset;
  assign push     = s_req & s_addr_ok;
  assign pop      = s_data_ok & (count_q != '0) & ~reset;
  assign head_id  = id_fifo_q[rd_ptr_q];
  assign m_rdata  = s_rdata;
  assign err_unexp = err_q;

  // Request mux from the granted master
  always_comb begin
    wr_mux    = 1'b0;
    size_mux  = 2'b00;
    addr_mux  = '0;
    wdata_mux = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (grant == IDW'(j)) begin
        wr_mux    = m_wr[j];
        size_mux  = m_size[2*j +: 2];
        addr_mux  = m_addr[32*j +: 32];
        wdata_mux = m_wdata[32*j +: 32];
      end
    end
  end

  assign s_wr    = wr_mux & ~reset;
  assign s_size  = reset ? 2'b00 : size_mux;
  assign s_addr  = reset ? 32'h0 : addr_mux;
  assign s_wdata = reset ? 32'h0 : wdata_mux;

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_strobe
      assign m_addr_ok[gi] = push & (grant == IDW'(gi));
      assign m_data_ok[gi] = pop & (head_id == IDW'(gi));
    end
  endgenerate

  // Next-state for occupancy, pointers, lock and the sticky error flag
  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (s_data_ok & (count_q == '0));
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (push) begin
      lock_d = 1'b0;
    end else if (s_req) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  // ID storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push) id_fifo_q[wr_ptr_q] <= grant;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter (2 masters, 4 outstanding).
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  m_req = 2'b11, m_wr, m_addr_ok, m_data_ok;
  logic [3:0]  m_size;
  logic [63:0] m_addr, m_wdata;
  logic [31:0] m_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok = 1'b1, s_data_ok = 1'b1;
  logic [31:0] s_rdata = 32'hCAFE_0001;
  logic        err_unexp;

  always #5 clk = ~clk;

  assign m_wr    = 2'b10;
  assign m_size  = {2'd1, 2'd2};
  assign m_addr  = {32'h2000_0004, 32'h1000_0000};
  assign m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};

  sram_like_arbiter #(.NUM_MASTERS(2), .OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata), .s_req(s_req), .s_wr(s_wr),
    .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err_unexp(err_unexp)
  );

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [1:0]  req;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        sreq;
    logic [1:0]  maok;
    int          gnt;
  } vec_t;

  vec_t       vecs [40];
  int         nvec = 0;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] sb_q [$];
  logic       err_exp = 1'b0;

  task automatic add(input logic [1:0] req, input logic aok, input logic dok,
                     input logic [31:0] rd, input logic sreq,
                     input logic [1:0] maok, input int gnt);
    vecs[nvec] = '{req, aok, dok, rd, sreq, maok, gnt};
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, compare at the falling edge
  task automatic run_row(input vec_t v, input int idx);
    logic [1:0] exp_dok;
    logic       set_err;
    @(posedge clk);
    #1;
    m_req = v.req; s_addr_ok = v.aok; s_data_ok = v.dok; s_rdata = v.rdata;
    @(negedge clk);
    exp_dok = 2'b00;
    set_err = 1'b0;
    if (v.dok) begin
      if (sb_q.size() > 0) exp_dok = sb_q.pop_front();
      else set_err = 1'b1;
    end
    check($sformatf("row%0d s_req", idx), 32'(s_req), 32'(v.sreq));
    check($sformatf("row%0d m_addr_ok", idx), 32'(m_addr_ok), 32'(v.maok));
    check($sformatf("row%0d m_data_ok", idx), 32'(m_data_ok), 32'(exp_dok));
    check($sformatf("row%0d m_rdata", idx), m_rdata, v.rdata);
    check($sformatf("row%0d err_unexp", idx), 32'(err_unexp), 32'(err_exp));
    if (v.sreq) begin
      check($sformatf("row%0d s_addr", idx), s_addr,
            (v.gnt == 0) ? 32'h1000_0000 : 32'h2000_0004);
      check($sformatf("row%0d s_wr", idx), 32'(s_wr), 32'(v.gnt));
    end
    if (v.maok != 2'b00) sb_q.push_back(v.maok);
    if (set_err) err_exp = 1'b1;
    $display("row %0d req=%b aok=%b dok=%b -> s_req=%b addr_ok=%b data_ok=%b(exp %b) err=%b",
             idx, v.req, v.aok, v.dok, s_req, m_addr_ok, m_data_ok, exp_dok, err_unexp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " s_req"}, 32'(s_req), 32'h0);
    check({tag, " m_addr_ok"}, 32'(m_addr_ok), 32'h0);
    check({tag, " m_data_ok"}, 32'(m_data_ok), 32'h0);
    check({tag, " s_addr"}, s_addr, 32'h0);
    check({tag, " s_wdata"}, s_wdata, 32'h0);
    check({tag, " s_wr_size"}, {29'h0, s_wr, s_size}, 32'h0);
    check({tag, " err_unexp"}, 32'(err_unexp), 32'h0);
    check({tag, " m_rdata"}, m_rdata, s_rdata);
    $display("%s: s_req=%b addr_ok=%b data_ok=%b rdata=%h", tag, s_req, m_addr_ok, m_data_ok, m_rdata);
  endtask

  initial begin
    vec_t v;
    // back-to-back handshakes with data one cycle later
    add(2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 0);
    add(2'b11, 1'b1, 1'b1, 32'h11, 1'b1, RR ? 2'b10 : 2'b01, RR ? 1 : 0);
    add(2'b11, 1'b1, 1'b1, 32'h22, 1'b1, 2'b01, 0);
    add(2'b11, 1'b1, 1'b1, 32'h33, 1'b1, RR ? 2'b10 : 2'b01, RR ? 1 : 0);
    add(2'b00, 1'b0, 1'b1, 32'h44, 1'b0, 2'b00, 0);
    // lock: master 1 stalls, master 0 joins, master 1 must stay granted
    add(2'b10, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 1);
    add(2'b10, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 1);
    add(2'b10, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 1);
    add(2'b11, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 1);
    add(2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b10, 1);
    add(2'b11, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 0);
    add(2'b01, 1'b1, 1'b1, 32'h55, 1'b1, 2'b01, 0);
    add(2'b00, 1'b0, 1'b1, 32'h66, 1'b0, 2'b00, 0);
    // fill to OUTSTANDING, then full cycle with a pop
    for (int i = 0; i < 4; i++) add(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 0);
    add(2'b01, 1'b1, 1'b1, 32'h77, 1'b0, 2'b00, 0);
    add(2'b01, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 0);
    for (int i = 0; i < 4; i++) add(2'b00, 1'b0, 1'b1, 32'h80 + 32'(i), 1'b0, 2'b00, 0);
    // unexpected data_ok on empty FIFO, then normal traffic
    add(2'b00, 1'b0, 1'b1, 32'h99, 1'b0, 2'b00, 0);
    add(2'b11, 1'b1, 1'b0, 32'h0,  1'b1, RR ? 2'b10 : 2'b01, RR ? 1 : 0);
    add(2'b00, 1'b0, 1'b1, 32'hA0, 1'b0, 2'b00, 0);

    // outputs while in reset with busy inputs
    #3;
    check_reset_outputs("reset0");
    @(posedge clk);
    #1;
    reset = 1'b0; m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;

    for (int i = 0; i < nvec; i++) run_row(vecs[i], i);

    // reset with two transactions in flight
    v = '{2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 0};
    run_row(v, 100);
    run_row(v, 101);
    @(posedge clk);
    #1;
    reset = 1'b1; m_req = 2'b11; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    check_reset_outputs("reset_mid");
    sb_q.delete();
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    run_row('{2'b00, 1'b0, 1'b1, 32'h5, 1'b0, 2'b00, 0}, 102);
    run_row('{2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 1}, 103);
    run_row('{2'b00, 1'b0, 1'b1, 32'h6, 1'b0, 2'b00, 0}, 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
